// File: rtl/itcm_rsp_pkg.sv
// itcm_rsp_pkg: shared constants and response entry type for the ITCM responder.
// The optional error checking is enabled by defining ITCM_ERR_EN (see itcm_rsp.sv).
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

package itcm_rsp_pkg;
  localparam int unsigned ITCM_AW_DEF = 10;
  localparam int unsigned ITCM_DEPTH  = 2 ** ITCM_AW_DEF;

  typedef struct packed {
    logic                   err;
    logic [`INSTR_SIZE-1:0] instr;
  } rsp_entry_t;
endpackage

// File: rtl/itcm_rsp_fifo.sv
// itcm_rsp_fifo: 2-entry in-order response FIFO (push/pop/count/head).
// Push and pop in the same cycle keep the count and advance both pointers.
module itcm_rsp_fifo #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  import itcm_rsp_pkg::*;

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Entry storage; contents need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap mod 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = slot[rd_ptr];
endmodule

// File: rtl/itcm_rsp.sv
// itcm_rsp: ITCM instruction responder at the far end of the IFU fetch path.
// Word-addressed array with synchronous read, bypass on an empty buffer, and a
// 2-entry response FIFO for back-pressure. Load port writes the array.
// Optional macro ITCM_ERR_EN: flag misaligned / out-of-range fetches with err=1.
module itcm_rsp
  import itcm_rsp_pkg::*;
#(
  parameter int unsigned PC_SIZE    = `PC_SIZE,
  parameter int unsigned INSTR_SIZE = `INSTR_SIZE,
  parameter int unsigned ITCM_AW    = ITCM_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_rsp_err,
  input  logic                  ld_en,
  input  logic [ITCM_AW-1:0]    ld_addr,
  input  logic [INSTR_SIZE-1:0] ld_data
);
  localparam int unsigned DEPTH = 2 ** ITCM_AW;

`ifdef ITCM_ERR_EN
  localparam int unsigned EW = INSTR_SIZE + 1;
`else
  localparam int unsigned EW = INSTR_SIZE;
`endif

  logic [INSTR_SIZE-1:0] mem [DEPTH];
  logic [INSTR_SIZE-1:0] mem_q;
  logic                  rd_pending;
  logic                  accept;
  logic                  rd_en;
  logic [ITCM_AW-1:0]    rd_idx;
  logic [EW-1:0]         rd_entry;
  logic [EW-1:0]         head;
  logic [EW-1:0]         out_entry;
  logic [1:0]            fifo_cnt;
  logic [1:0]            occ;
  logic                  push;
  logic                  pop;

  assign accept = ifu_req_valid & ifu_req_ready;
  assign rd_idx = ifu_req_pc[ITCM_AW+1:2];

`ifdef ITCM_ERR_EN
  logic req_err;
  logic rd_err;

  assign req_err  = (ifu_req_pc[1:0] != 2'b00) | (ifu_req_pc[PC_SIZE-1:ITCM_AW+2] != '0);
  assign rd_en    = accept & ~req_err;
  assign rd_entry = {rd_err, mem_q & {INSTR_SIZE{~rd_err}}};

  // Error flag travelling alongside the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) rd_err <= 1'b0;
    else     rd_err <= accept & req_err;
  end
`else
  logic unused_pc;

  assign unused_pc = ^{ifu_req_pc[PC_SIZE-1:ITCM_AW+2], ifu_req_pc[1:0]};
  assign rd_en     = accept;
  assign rd_entry  = mem_q;
`endif

  // Array: load write and fetch read share a cycle; the read sees the old word.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (rd_en) mem_q <= mem[rd_idx];
  end

  // Marks the cycle in which mem_q holds a freshly read response.
  always_ff @(posedge clk) begin
    if (rst) rd_pending <= 1'b0;
    else     rd_pending <= accept;
  end

  // Bypass only when the FIFO is empty and the IFU takes the word at once.
  assign pop  = ifu_rsp_ready & (fifo_cnt != 2'd0);
  assign push = rd_pending & ~((fifo_cnt == 2'd0) & ifu_rsp_ready);

  itcm_rsp_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rd_entry),
    .head  (head),
    .count (fifo_cnt)
  );

  assign occ           = fifo_cnt + {1'b0, rd_pending};
  assign ifu_req_ready = (occ < 2'd2);
  assign ifu_rsp_valid = (fifo_cnt != 2'd0) | rd_pending;

  // Response source: FIFO head first to keep request order, else the bypass.
  always_comb begin
    out_entry = '0;
    if (fifo_cnt != 2'd0) out_entry = head;
    else if (rd_pending)  out_entry = rd_entry;
  end

  assign ifu_rsp_instr = out_entry[INSTR_SIZE-1:0];
`ifdef ITCM_ERR_EN
  assign ifu_rsp_err = out_entry[INSTR_SIZE];
`else
  assign ifu_rsp_err = 1'b0;
`endif
endmodule
